// File: rtl/ring_shift_reg.sv
// Parametrised DEPTH x WIDTH register ring: hold, shift, forward/reverse rotate, parallel load, clear-to-token.
// Latency: one clock from mode/sin/pin to stage registers; sout/pout/tap_out are combinational from stages.
// Backpressure: none; en=0 freezes all state and forces wrap low.
module ring_shift_reg #(
    parameter int WIDTH      = 1,
    parameter int DEPTH      = 5,
    parameter int INIT_STAGE = 2,
    parameter int INIT_VAL   = 1,
    localparam int CW        = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [2:0]             mode,
    input  logic [WIDTH-1:0]       sin,
    input  logic [DEPTH*WIDTH-1:0] pin,
    input  logic [CW-1:0]          tap_sel,
    output logic [WIDTH-1:0]       sout,
    output logic [DEPTH*WIDTH-1:0] pout,
    output logic [WIDTH-1:0]       tap_out,
    output logic [CW-1:0]          rot_cnt,
    output logic                   wrap
);

    localparam logic [2:0] MODE_HOLD    = 3'b000;
    localparam logic [2:0] MODE_SHIFT   = 3'b001;
    localparam logic [2:0] MODE_ROT_FWD = 3'b010;
    localparam logic [2:0] MODE_ROT_REV = 3'b011;
    localparam logic [2:0] MODE_LOAD    = 3'b100;
    localparam logic [2:0] MODE_CLEAR   = 3'b101;

    localparam logic [CW-1:0] ROT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ROT_ONE  = CW'(1);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [CW-1:0]    rot_q;
    logic [CW-1:0]    rot_d;
    logic             wrap_q;
    logic             wrap_d;

    function automatic logic [WIDTH-1:0] init_of(input int idx);
        return (idx == INIT_STAGE) ? WIDTH'(INIT_VAL) : '0;
    endfunction

    always_comb begin
        stage_d = stage_q;
        rot_d   = rot_q;
        wrap_d  = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHIFT: begin
                    stage_d[0] = sin;
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                end
                MODE_ROT_FWD: begin
                    stage_d[0] = stage_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                    rot_d  = (rot_q == ROT_LAST) ? '0 : rot_q + ROT_ONE;
                    wrap_d = (rot_q == ROT_LAST);
                end
                MODE_ROT_REV: begin
                    stage_d[DEPTH-1] = stage_q[0];
                    for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
                    rot_d  = (rot_q == '0) ? ROT_LAST : rot_q - ROT_ONE;
                    // reverse step lands on zero only from position one
                    wrap_d = (rot_q == ROT_ONE);
                end
                MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) stage_d[i] = pin[i*WIDTH +: WIDTH];
                    rot_d = '0;
                end
                MODE_CLEAR: begin
                    for (int i = 0; i < DEPTH; i++) stage_d[i] = init_of(i);
                    rot_d = '0;
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= init_of(i);
            rot_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            rot_q   <= rot_d;
            wrap_q  <= wrap_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign pout[g*WIDTH +: WIDTH] = stage_q[g];
    end

    always_comb begin
        tap_out = '0;
        if (int'(tap_sel) < DEPTH) tap_out = stage_q[tap_sel];
    end

    assign sout    = stage_q[DEPTH-1];
    assign rot_cnt = rot_q;
    assign wrap    = wrap_q;

endmodule
